alu_issue_sequencer: RTL and testbench

Multi-cycle issue/write-back controller that drives the existing 32-bit ALU (op ADD/ADDI=4'b0000, SUB=4'b0001, ORI/OR=4'b0010) from the operand/opcode side. It accepts one RV32I instruction per handshake, decodes it, and reads operands from an internal register file. It then presents the operation code and operands to the ALU, captures the result and zero flag, and writes the result back to rd. This block is the control/operand front end for the ALU in the multi-cycle core variant.

---
 rtl/alu_issue_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sequencer.sv
// Multi-cycle issue/write-back controller in front of the 32-bit ALU:
// accepts one RV32I ALU instruction, reads operands, drives the ALU, writes rd.
module alu_issue_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Instr_i,
  input  logic                  Instr_Valid_i,
  output logic                  Instr_Ready_o,
  output logic [3:0]            ALU_Operation_o,
  output logic [DATA_WIDTH-1:0] ALU_A_o,
  output logic [DATA_WIDTH-1:0] ALU_B_o,
  input  logic [DATA_WIDTH-1:0] ALU_Result_i,
  input  logic                  ALU_Zero_i,
  output logic                  Zero_o,
  output logic                  Done_o,
  output logic                  Illegal_o,
  input  logic [4:0]            Dbg_Addr_i,
  output logic [DATA_WIDTH-1:0] Dbg_Data_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           instr_q, instr_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

  logic [6:0]            opcode_s;
  logic [2:0]            funct3_s;
  logic [6:0]            funct7_s;
  logic [4:0]            rs1_s, rs2_s, rd_s;
  logic [DATA_WIDTH-1:0] rs1_val_s, rs2_val_s, imm_s;
  logic                  legal_s;
  logic [3:0]            dec_op_s;
  logic [DATA_WIDTH-1:0] dec_b_s;

  assign opcode_s  = instr_q[6:0];
  assign rd_s      = instr_q[11:7];
  assign funct3_s  = instr_q[14:12];
  assign rs1_s     = instr_q[19:15];
  assign rs2_s     = instr_q[24:20];
  assign funct7_s  = instr_q[31:25];
  assign imm_s     = {{(DATA_WIDTH-12){instr_q[31]}}, instr_q[31:20]};
  // x0 is hardwired to zero on every read port
  assign rs1_val_s  = (rs1_s == 5'd0) ? {DATA_WIDTH{1'b0}} : regs_q[rs1_s];
  assign rs2_val_s  = (rs2_s == 5'd0) ? {DATA_WIDTH{1'b0}} : regs_q[rs2_s];
  assign Dbg_Data_o = (Dbg_Addr_i == 5'd0) ? {DATA_WIDTH{1'b0}} : regs_q[Dbg_Addr_i];

  assign Instr_Ready_o   = (state_q == IDLE);
  assign Done_o          = (state_q == WRITEBACK);
  assign Illegal_o       = (state_q == FAULT);
  assign ALU_Operation_o = op_q;
  assign ALU_A_o         = a_q;
  assign ALU_B_o         = b_q;
  assign Zero_o          = zero_q;

  // Instruction decode of the latched word: legality, ALU op and operand B
  always_comb begin
    legal_s  = 1'b0;
    dec_op_s = 4'b0000;
    dec_b_s  = rs2_val_s;
    case (opcode_s)
      7'b0110011: begin
        if ((funct3_s == 3'b000) && (funct7_s == 7'b0000000)) begin
          legal_s = 1'b1;
        end else if ((funct3_s == 3'b000) && (funct7_s == 7'b0100000)) begin
          legal_s  = 1'b1;
          dec_op_s = 4'b0001;
        end else begin
          legal_s = 1'b0;
        end
      end
      7'b0010011: begin
        dec_b_s = imm_s;
        case (funct3_s)
          3'b000:  legal_s = 1'b1;
          3'b110: begin
            legal_s  = 1'b1;
            dec_op_s = 4'b0010;
          end
          default: legal_s = 1'b0;
        endcase
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Sequencer next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    wr_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Instr_Valid_i) begin
          instr_d = Instr_i;
          state_d = DECODE;
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        if (legal_s) begin
          op_d    = dec_op_s;
          a_d     = rs1_val_s;
          b_d     = dec_b_s;
          state_d = EXECUTE;
        end else begin
          state_d = FAULT;
        end
      end
      EXECUTE: begin
        result_d = ALU_Result_i;
        zero_d   = ALU_Zero_i;
        state_d  = WRITEBACK;
      end
      WRITEBACK: begin
        wr_en_s = (rd_s != 5'd0);
        state_d = IDLE;
      end
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      instr_q  <= 32'h0000_0000;
      op_q     <= 4'b0000;
      a_q      <= {DATA_WIDTH{1'b0}};
      b_q      <= {DATA_WIDTH{1'b0}};
      result_q <= {DATA_WIDTH{1'b0}};
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // Architectural register file; entry 0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_q[rd_s] <= result_q;
    end else begin
      regs_q[0] <= {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Self-checking bench for alu_issue_sequencer: ALU stub, reference register
// model and an expected-result queue popped as each instruction completes.
module tb_alu_issue_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_i;
  logic        Instr_Valid_i;
  logic        Instr_Ready_o;
  logic [3:0]  ALU_Operation_o;
  logic [31:0] ALU_A_o, ALU_B_o, ALU_Result_i;
  logic        ALU_Zero_i, Zero_o, Done_o, Illegal_o;
  logic [4:0]  Dbg_Addr_i;
  logic [31:0] Dbg_Data_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_issue_sequencer #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
    .clk(clk), .reset(reset), .Instr_i(Instr_i), .Instr_Valid_i(Instr_Valid_i),
    .Instr_Ready_o(Instr_Ready_o), .ALU_Operation_o(ALU_Operation_o),
    .ALU_A_o(ALU_A_o), .ALU_B_o(ALU_B_o), .ALU_Result_i(ALU_Result_i),
    .ALU_Zero_i(ALU_Zero_i), .Zero_o(Zero_o), .Done_o(Done_o), .Illegal_o(Illegal_o),
    .Dbg_Addr_i(Dbg_Addr_i), .Dbg_Data_o(Dbg_Data_o)
  );

  // Stand-in for the external combinational ALU
  always_comb begin
    case (ALU_Operation_o)
      4'b0000: ALU_Result_i = ALU_A_o + ALU_B_o;
      4'b0001: ALU_Result_i = ALU_A_o - ALU_B_o;
      4'b0010: ALU_Result_i = ALU_A_o | ALU_B_o;
      default: ALU_Result_i = 32'h0;
    endcase
    ALU_Zero_i = (ALU_Result_i == 32'h0);
  end

  typedef struct packed {
    bit          legal;
    logic [3:0]  op;
    logic [31:0] a, b, dbg;
    logic        zero;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [32];
  logic        mzero;
  logic [3:0]  mop;
  logic [31:0] ma, mb;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mzero = 1'b0; mop = 4'b0000; ma = 32'h0; mb = 32'h0;
  endtask

  // Reference decode/execute; pushes the expectation and advances the model
  task automatic push_expect(input logic [31:0] ins);
    exp_t e;
    logic [31:0] rs1v, rs2v, imm, res;
    rs1v = (ins[19:15] == 5'd0) ? 32'h0 : mregs[ins[19:15]];
    rs2v = (ins[24:20] == 5'd0) ? 32'h0 : mregs[ins[24:20]];
    imm  = {{20{ins[31]}}, ins[31:20]};
    e = '0;
    e.rd = ins[11:7]; e.op = mop; e.a = ma; e.b = mb; e.zero = mzero;
    if (ins[6:0] == 7'b0110011 && ins[14:12] == 3'b000 && ins[31:25] == 7'b0000000) begin
      e.legal = 1'b1; e.op = 4'b0000; e.a = rs1v; e.b = rs2v; res = rs1v + rs2v;
    end else if (ins[6:0] == 7'b0110011 && ins[14:12] == 3'b000 && ins[31:25] == 7'b0100000) begin
      e.legal = 1'b1; e.op = 4'b0001; e.a = rs1v; e.b = rs2v; res = rs1v - rs2v;
    end else if (ins[6:0] == 7'b0010011 && ins[14:12] == 3'b000) begin
      e.legal = 1'b1; e.op = 4'b0000; e.a = rs1v; e.b = imm; res = rs1v + imm;
    end else if (ins[6:0] == 7'b0010011 && ins[14:12] == 3'b110) begin
      e.legal = 1'b1; e.op = 4'b0010; e.a = rs1v; e.b = imm; res = rs1v | imm;
    end else begin
      res = 32'h0;
    end
    if (e.legal) begin
      e.zero = (res == 32'h0);
      e.dbg  = (e.rd == 5'd0) ? 32'h0 : res;
      if (e.rd != 5'd0) mregs[e.rd] = res;
      mzero = e.zero; mop = e.op; ma = e.a; mb = e.b;
    end
    sb.push_back(e);
  endtask

  // Handshake one instruction and observe a fixed window of cycles after it
  task automatic issue(input logic [31:0] ins, input int hold_k,
                       output int done_k, output int ready_k, output int ill_k,
                       output int done_n, output int ill_n,
                       output logic [3:0] op, output logic [31:0] a, output logic [31:0] b,
                       output bit to);
    int w = 0;
    to = 1'b0; done_k = 0; ready_k = 0; ill_k = 0; done_n = 0; ill_n = 0;
    op = 4'hx; a = 32'hx; b = 32'hx;
    @(negedge clk);
    while (!Instr_Ready_o && w < 20) begin @(negedge clk); w++; end
    if (!Instr_Ready_o) begin to = 1'b1; return; end
    Instr_i = ins; Instr_Valid_i = 1'b1;
    push_expect(ins);
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k > hold_k) Instr_Valid_i = 1'b0;
      if (Done_o) begin done_n++; if (done_k == 0) done_k = k; end
      if (Illegal_o) begin ill_n++; if (ill_k == 0) ill_k = k; end
      if (Instr_Ready_o && ready_k == 0) ready_k = k;
      if (k == 2) begin op = ALU_Operation_o; a = ALU_A_o; b = ALU_B_o; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; Instr_Valid_i = 1'b0; Instr_i = 32'h0; Dbg_Addr_i = 5'd1;
    model_reset();
    #12;
    total_cnt++; if (Instr_Ready_o !== 1'b1) $display("FAIL rst_ready got %b exp 1", Instr_Ready_o); else pass_cnt++;
    total_cnt++; if ({ALU_Operation_o, ALU_A_o, ALU_B_o} !== 68'h0) $display("FAIL rst_alu got %h/%h/%h exp 0", ALU_Operation_o, ALU_A_o, ALU_B_o); else pass_cnt++;
    total_cnt++; if ({Zero_o, Done_o, Illegal_o} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {Zero_o, Done_o, Illegal_o}); else pass_cnt++;
    total_cnt++; if (Dbg_Data_o !== 32'h0) $display("FAIL rst_x1 got %h exp 0", Dbg_Data_o); else pass_cnt++;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_legal(input string nm, input logic [31:0] ins);
    int dk, rk, ik, dn, in_n; logic [3:0] op; logic [31:0] a, b; bit to; exp_t e;
    issue(ins, 0, dk, rk, ik, dn, in_n, op, a, b, to);
    total_cnt++; if (to) $display("FAIL %s_timeout got no ready exp ready", nm); else pass_cnt++;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    Dbg_Addr_i = e.rd; #1;
    total_cnt++; if ({op, a, b} !== {e.op, e.a, e.b}) $display("FAIL %s_alu got %h/%h/%h exp %h/%h/%h", nm, op, a, b, e.op, e.a, e.b); else pass_cnt++;
    total_cnt++; if (dk !== 3 || dn !== 1 || in_n !== 0) $display("FAIL %s_done got k=%0d n=%0d ill=%0d exp k=3 n=1 ill=0", nm, dk, dn, in_n); else pass_cnt++;
    total_cnt++; if (rk !== 4) $display("FAIL %s_ready got %0d exp 4", nm, rk); else pass_cnt++;
    total_cnt++; if (Zero_o !== e.zero) $display("FAIL %s_zero got %b exp %b", nm, Zero_o, e.zero); else pass_cnt++;
    total_cnt++; if (Dbg_Data_o !== e.dbg) $display("FAIL %s_rd got %h exp %h", nm, Dbg_Data_o, e.dbg); else pass_cnt++;
  endtask

  task automatic test_add_chain();
    test_legal("addi_neg", 32'hFFD00113);
    test_legal("add", 32'h002081B3);
    Dbg_Addr_i = 5'd3; #1;
    total_cnt++; if (Dbg_Data_o !== 32'h0000_0002) $display("FAIL add_x3_const got %h exp 00000002", Dbg_Data_o); else pass_cnt++;
  endtask

  task automatic test_illegal();
    int dk, rk, ik, dn, in_n; logic [3:0] op; logic [31:0] a, b; bit to; exp_t e;
    issue(32'h00001033, 2, dk, rk, ik, dn, in_n, op, a, b, to);
    total_cnt++; if (to) $display("FAIL ill_timeout got no ready exp ready"); else pass_cnt++;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    Dbg_Addr_i = 5'd5; #1;
    total_cnt++; if (e.legal !== 1'b0 || ik !== 2 || in_n !== 1 || dn !== 0) $display("FAIL ill_pulse got k=%0d n=%0d done=%0d exp k=2 n=1 done=0", ik, in_n, dn); else pass_cnt++;
    total_cnt++; if (rk !== 3) $display("FAIL ill_ready got %0d exp 3", rk); else pass_cnt++;
    total_cnt++; if ({op, a, b} !== {e.op, e.a, e.b}) $display("FAIL ill_alu_hold got %h/%h/%h exp %h/%h/%h", op, a, b, e.op, e.a, e.b); else pass_cnt++;
    total_cnt++; if (Zero_o !== e.zero) $display("FAIL ill_zero got %b exp %b", Zero_o, e.zero); else pass_cnt++;
    total_cnt++; if (Dbg_Data_o !== mregs[5]) $display("FAIL ill_x5 got %h exp %h", Dbg_Data_o, mregs[5]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int dn = 0; int w = 0;
    @(negedge clk);
    while (!Instr_Ready_o && w < 20) begin @(negedge clk); w++; end
    total_cnt++; if (!Instr_Ready_o) $display("FAIL rmid_ready got 0 exp 1"); else pass_cnt++;
    Instr_i = 32'h00900313; Instr_Valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk); Instr_Valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b0; model_reset(); #1;
    Dbg_Addr_i = 5'd1; #1;
    total_cnt++; if ({ALU_Operation_o, ALU_A_o, ALU_B_o} !== 68'h0) $display("FAIL rmid_alu got %h/%h/%h exp 0", ALU_Operation_o, ALU_A_o, ALU_B_o); else pass_cnt++;
    total_cnt++; if ({Instr_Ready_o, Zero_o, Done_o, Illegal_o} !== 4'b1000) $display("FAIL rmid_flags got %b exp 1000", {Instr_Ready_o, Zero_o, Done_o, Illegal_o}); else pass_cnt++;
    total_cnt++; if (Dbg_Data_o !== 32'h0) $display("FAIL rmid_x1 got %h exp 0", Dbg_Data_o); else pass_cnt++;
    @(negedge clk); reset = 1'b1;
    Dbg_Addr_i = 5'd6;
    for (int k = 0; k < 5; k++) begin @(negedge clk); if (Done_o) dn++; end
    total_cnt++; if (dn !== 0 || Dbg_Data_o !== 32'h0) $display("FAIL rmid_nowb got done=%0d x6=%h exp 0/0", dn, Dbg_Data_o); else pass_cnt++;
    test_legal("addi_x6", 32'h00900313);
  endtask

  initial begin
    test_reset();
    test_legal("addi_x1", 32'h00500093);
    test_add_chain();
    test_legal("sub_x4", 32'h40108233);
    test_legal("ori_x5", 32'h0F006293);
    test_legal("addi_x0", 32'h00700013);
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
